// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer with per-entry saturating direction counters.
// Combinational next-PC prediction for IF, registered training from EX, and a mispredict counter.
module branch_target_buffer #(
  parameter int WORD_W  = 32,
  parameter int ENTRIES = 16,
  parameter int TAG_W   = 8,
  parameter int CTR_W   = 2,
  parameter int CNT_W   = 32
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic [WORD_W-1:0] lookup_pc,
  output logic              hit,
  output logic              predict_taken,
  output logic [WORD_W-1:0] predict_npc,
  input  logic              upd_en,
  input  logic [WORD_W-1:0] upd_pc,
  input  logic              upd_taken,
  input  logic [WORD_W-1:0] upd_target,
  input  logic              upd_mispredict,
  input  logic              invalidate,
  output logic [CNT_W-1:0]  mispred_cnt
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TGT_W = WORD_W - 2;
  localparam logic [CTR_W-1:0] CTR_WEAK = CTR_W'(1 << (CTR_W - 1));

  logic [ENTRIES-1:0] valid;
  logic [TAG_W-1:0]   tags    [ENTRIES];
  logic [TGT_W-1:0]   targets [ENTRIES];
  logic [CTR_W-1:0]   ctrs    [ENTRIES];

  logic [IDX_W-1:0] lk_idx, up_idx;
  logic [TAG_W-1:0] lk_tag, up_tag;
  logic             up_hit;
  logic             unused_bits;

  assign lk_idx = lookup_pc[IDX_W+1:2];
  assign lk_tag = lookup_pc[IDX_W+2+TAG_W-1:IDX_W+2];
  assign up_idx = upd_pc[IDX_W+1:2];
  assign up_tag = upd_pc[IDX_W+2+TAG_W-1:IDX_W+2];
  assign unused_bits = ^{lookup_pc, upd_pc, upd_target[1:0]};

  always_comb begin
    hit           = valid[lk_idx] && (tags[lk_idx] == lk_tag);
    predict_taken = hit && ctrs[lk_idx][CTR_W-1];
    predict_npc   = predict_taken ? {targets[lk_idx], 2'b00}
                                  : lookup_pc + WORD_W'(4);
  end

  assign up_hit = valid[up_idx] && (tags[up_idx] == up_tag);

  // Lookup reads the array directly, so a same-cycle update is only seen next cycle.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      valid <= '0;
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        tags[i]    <= '0;
        targets[i] <= '0;
        ctrs[i]    <= '0;
      end
    end else if (invalidate) begin
      valid <= '0;
    end else if (upd_en) begin
      if (up_hit) begin
        if (upd_taken) begin
          targets[up_idx] <= upd_target[WORD_W-1:2];
          if (ctrs[up_idx] != '1) ctrs[up_idx] <= ctrs[up_idx] + CTR_W'(1);
        end else if (ctrs[up_idx] != '0) begin
          ctrs[up_idx] <= ctrs[up_idx] - CTR_W'(1);
        end
      end else if (upd_taken) begin
        valid[up_idx]   <= 1'b1;
        tags[up_idx]    <= up_tag;
        targets[up_idx] <= upd_target[WORD_W-1:2];
        ctrs[up_idx]    <= CTR_WEAK;
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      mispred_cnt <= '0;
    end else if (upd_en && upd_mispredict && (mispred_cnt != '1)) begin
      mispred_cnt <= mispred_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_branch_target_buffer.sv
// Bench for branch_target_buffer: directed vector table, reset corner cases,
// and randomized traffic against an array-based reference model.
module tb_branch_target_buffer;

  localparam int ENTRIES = 16;
  localparam int TAG_W   = 8;
  localparam int IDX_W   = 4;

  logic        CLK = 1'b0;
  logic        nRST;
  logic [31:0] lookup_pc, upd_pc, upd_target;
  logic        upd_en, upd_taken, upd_mispredict, invalidate;
  logic        hit, predict_taken, hit_s, predict_taken_s;
  logic [31:0] predict_npc, predict_npc_s, mispred_cnt;
  logic [1:0]  mispred_cnt_s;

  int checks = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  branch_target_buffer dut (
    .CLK(CLK), .nRST(nRST), .lookup_pc(lookup_pc), .hit(hit),
    .predict_taken(predict_taken), .predict_npc(predict_npc),
    .upd_en(upd_en), .upd_pc(upd_pc), .upd_taken(upd_taken),
    .upd_target(upd_target), .upd_mispredict(upd_mispredict),
    .invalidate(invalidate), .mispred_cnt(mispred_cnt)
  );

  branch_target_buffer #(.CNT_W(2)) dut_small (
    .CLK(CLK), .nRST(nRST), .lookup_pc(lookup_pc), .hit(hit_s),
    .predict_taken(predict_taken_s), .predict_npc(predict_npc_s),
    .upd_en(upd_en), .upd_pc(upd_pc), .upd_taken(upd_taken),
    .upd_target(upd_target), .upd_mispredict(upd_mispredict),
    .invalidate(invalidate), .mispred_cnt(mispred_cnt_s)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [31:0] lk;
    logic        en;
    logic [31:0] pc;
    logic        tk;
    logic [31:0] tgt;
    logic        mp;
    logic        inv;
    logic        e_hit;
    logic        e_pt;
    logic [31:0] e_npc;
    logic [1:0]  e_cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic [31:0] lk, logic en, logic [31:0] pc, logic tk,
                              logic [31:0] tgt, logic mp, logic inv, logic eh,
                              logic ep, logic [31:0] en_pc, logic [1:0] ec);
    vec_t v;
    v.lk = lk; v.en = en; v.pc = pc; v.tk = tk; v.tgt = tgt; v.mp = mp; v.inv = inv;
    v.e_hit = eh; v.e_pt = ep; v.e_npc = en_pc; v.e_cnt = ec;
    return v;
  endfunction

  // Reference model state: plain arrays indexed by arithmetic on the PC
  bit       m_valid [ENTRIES];
  int       m_tag   [ENTRIES];
  bit [31:0] m_tgt  [ENTRIES];
  int       m_ctr   [ENTRIES];
  longint   m_cnt;
  int       m_cnt_s;

  function automatic int idx_of(logic [31:0] pc);
    return int'((pc / 4) % ENTRIES);
  endfunction

  function automatic int tag_of(logic [31:0] pc);
    return int'((pc / (4 * ENTRIES)) % (2 ** TAG_W));
  endfunction

  task automatic model_clear();
    for (int i = 0; i < ENTRIES; i++) begin
      m_valid[i] = 0; m_tag[i] = 0; m_tgt[i] = '0; m_ctr[i] = 0;
    end
    m_cnt = 0; m_cnt_s = 0;
  endtask

  task automatic model_edge();
    int i, t;
    i = idx_of(upd_pc);
    t = tag_of(upd_pc);
    if (invalidate) begin
      for (int k = 0; k < ENTRIES; k++) m_valid[k] = 0;
    end else if (upd_en) begin
      if (m_valid[i] && m_tag[i] == t) begin
        if (upd_taken) begin
          m_ctr[i] = (m_ctr[i] == 3) ? 3 : m_ctr[i] + 1;
          m_tgt[i] = {upd_target[31:2], 2'b00};
        end else begin
          m_ctr[i] = (m_ctr[i] == 0) ? 0 : m_ctr[i] - 1;
        end
      end else if (upd_taken) begin
        m_valid[i] = 1; m_tag[i] = t; m_tgt[i] = {upd_target[31:2], 2'b00}; m_ctr[i] = 2;
      end
    end
    if (upd_en && upd_mispredict) begin
      m_cnt++;
      if (m_cnt_s < 3) m_cnt_s++;
    end
  endtask

  task automatic drive_idle();
    upd_en = 0; upd_pc = '0; upd_taken = 0; upd_target = '0;
    upd_mispredict = 0; invalidate = 0;
  endtask

  function automatic logic [31:0] rand_pc();
    logic [31:0] p;
    if ($urandom_range(9) == 0) p = $urandom;
    else p = ($urandom_range(3) << (2 + IDX_W)) | ($urandom_range(ENTRIES - 1) << 2)
             | $urandom_range(3);
    return p;
  endfunction

  initial begin
    vec_t v;
    logic [31:0] exp_npc;
    bit e_hit, e_pt;
    int li;

    nRST = 0; lookup_pc = 32'h100; drive_idle();
    #12;
    chk("reset_hit", {31'b0, hit}, 0);
    chk("reset_pt", {31'b0, predict_taken}, 0);
    chk("reset_npc", predict_npc, 32'h104);
    chk("reset_cnt", mispred_cnt, 0);
    @(negedge CLK) nRST = 1;

    // lookup, en, pc, taken, target, mp, inv, exp hit, exp pt, exp npc, exp small cnt after edge
    vecs.push_back(mk(32'h100, 0, 32'h000, 0, 32'h000, 0, 0, 0, 0, 32'h104, 0));
    vecs.push_back(mk(32'h100, 1, 32'h100, 1, 32'h200, 1, 0, 0, 0, 32'h104, 1));
    vecs.push_back(mk(32'h100, 1, 32'h100, 1, 32'h200, 1, 0, 1, 1, 32'h200, 2));
    vecs.push_back(mk(32'h100, 1, 32'h100, 1, 32'h200, 1, 0, 1, 1, 32'h200, 3));
    vecs.push_back(mk(32'h100, 1, 32'h100, 0, 32'h000, 1, 0, 1, 1, 32'h200, 3));
    vecs.push_back(mk(32'h100, 1, 32'h100, 0, 32'h000, 1, 0, 1, 1, 32'h200, 3));
    vecs.push_back(mk(32'h100, 1, 32'h100, 0, 32'h000, 0, 0, 1, 0, 32'h104, 3));
    vecs.push_back(mk(32'h100, 1, 32'h100, 0, 32'h000, 0, 0, 1, 0, 32'h104, 3));
    vecs.push_back(mk(32'h100, 0, 32'h100, 1, 32'h000, 1, 0, 1, 0, 32'h104, 3));
    vecs.push_back(mk(32'h100, 1, 32'h100, 1, 32'h200, 0, 0, 1, 0, 32'h104, 3));
    vecs.push_back(mk(32'h100, 1, 32'h100, 1, 32'h200, 0, 0, 1, 0, 32'h104, 3));
    vecs.push_back(mk(32'h100, 1, 32'h140, 1, 32'h300, 0, 0, 1, 1, 32'h200, 3));
    vecs.push_back(mk(32'h100, 0, 32'h000, 0, 32'h000, 0, 0, 0, 0, 32'h104, 3));
    vecs.push_back(mk(32'h140, 1, 32'h180, 0, 32'h500, 0, 0, 1, 1, 32'h300, 3));
    vecs.push_back(mk(32'h140, 0, 32'h000, 0, 32'h000, 0, 0, 1, 1, 32'h300, 3));
    vecs.push_back(mk(32'h140, 1, 32'h104, 1, 32'h400, 0, 1, 1, 1, 32'h300, 3));
    vecs.push_back(mk(32'h140, 0, 32'h000, 0, 32'h000, 0, 0, 0, 0, 32'h144, 3));
    vecs.push_back(mk(32'h104, 0, 32'h000, 0, 32'h000, 0, 0, 0, 0, 32'h108, 3));
    vecs.push_back(mk(32'hFFFFFFFC, 0, 32'h000, 0, 32'h000, 0, 0, 0, 0, 32'h0, 3));

    for (int r = 0; r < vecs.size(); r++) begin
      v = vecs[r];
      lookup_pc = v.lk; upd_en = v.en; upd_pc = v.pc; upd_taken = v.tk;
      upd_target = v.tgt; upd_mispredict = v.mp; invalidate = v.inv;
      #1;
      chk($sformatf("vec%0d_hit", r), {31'b0, hit}, {31'b0, v.e_hit});
      chk($sformatf("vec%0d_pt", r), {31'b0, predict_taken}, {31'b0, v.e_pt});
      chk($sformatf("vec%0d_npc", r), predict_npc, v.e_npc);
      @(posedge CLK); #1;
      chk($sformatf("vec%0d_cnt_small", r), {30'b0, mispred_cnt_s}, {30'b0, v.e_cnt});
      @(negedge CLK);
    end

    // Async reset in the middle of a training update
    lookup_pc = 32'h100; upd_en = 1; upd_pc = 32'h100; upd_taken = 1;
    upd_target = 32'h600; upd_mispredict = 1;
    #2 nRST = 0;
    #1;
    chk("async_cnt_small", {30'b0, mispred_cnt_s}, 0);
    chk("async_cnt", mispred_cnt, 0);
    chk("async_hit", {31'b0, hit}, 0);
    chk("async_npc", predict_npc, 32'h104);
    @(posedge CLK); #1;
    chk("rst_edge_cnt", mispred_cnt, 0);
    @(negedge CLK);
    drive_idle(); nRST = 1;
    #1;
    chk("post_rst_hit", {31'b0, hit}, 0);
    chk("post_rst_npc", predict_npc, 32'h104);
    @(negedge CLK);

    model_clear();
    for (int c = 0; c < 3000; c++) begin
      lookup_pc = rand_pc();
      upd_en = ($urandom_range(3) != 0);
      upd_pc = ($urandom_range(3) == 0) ? lookup_pc : rand_pc();
      upd_taken = $urandom_range(1);
      upd_target = $urandom;
      upd_mispredict = $urandom_range(1);
      invalidate = ($urandom_range(60) == 0);
      #1;
      li = idx_of(lookup_pc);
      e_hit = m_valid[li] && (m_tag[li] == tag_of(lookup_pc));
      e_pt = e_hit && (m_ctr[li] >= 2);
      exp_npc = e_pt ? m_tgt[li] : lookup_pc + 32'd4;
      chk("rnd_hit", {31'b0, hit}, {31'b0, e_hit});
      chk("rnd_pt", {31'b0, predict_taken}, {31'b0, e_pt});
      chk("rnd_npc", predict_npc, exp_npc);
      @(posedge CLK);
      model_edge();
      #1;
      chk("rnd_cnt", mispred_cnt, m_cnt[31:0]);
      chk("rnd_cnt_small", {30'b0, mispred_cnt_s}, m_cnt_s);
      @(negedge CLK);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
